key_stream_tx: RTL and testbench

KEY_STREAM_TX -- requirements
Module: key_stream_tx

---
 rtl/key_stream_pkg.sv | 20 ++
 rtl/key_shift_reg.sv | 38 +++
 rtl/key_stream_tx.sv | 128 ++++++++++++
 tb/tb_key_stream_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_stream_pkg.sv
// Shared types and helpers for the serial key transmitter.
// Holds the FSM state encoding and the key parity function.
package key_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_PAR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int MAX_KEY_W = 64;

    // Even parity over a zero-extended key; the extension bits do not change the result.
    function automatic logic key_parity(input logic [MAX_KEY_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Key shift register: parallel load, LSB-first right shift on enable,
// and the parity of the loaded word held alongside it.
module key_shift_reg
    import key_stream_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_lsb,
    output logic         o_lsb_next,
    output logic         o_parity
);

    logic [W-1:0] r_data;
    logic         r_parity;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data   <= '0;
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_data   <= i_data;
            r_parity <= key_parity(MAX_KEY_W'(i_data));
        end else if (i_shift) begin
            r_data   <= {1'b0, r_data[W-1:1]};
        end
    end

    // Bit 1 is what bit 0 becomes after a shift, so the top can register key_bit ahead.
    assign o_lsb      = r_data[0];
    assign o_lsb_next = r_data[1];
    assign o_parity   = r_parity;

endmodule

// File: rtl/key_stream_tx.sv
// Serial key transmitter: captures a parallel key on start and shifts it out
// LSB first under a valid/ready handshake, optionally followed by an even-parity bit.
module key_stream_tx
    import key_stream_pkg::*;
#(
    parameter int KEY_W     = 16,
    parameter int PARITY_EN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [KEY_W-1:0]             key_word,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         key_ready,
    output logic                         key_bit,
    output logic                         key_valid,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(KEY_W+1)-1:0]   bit_idx,
    output logic [2:0]                   dbg_state
);

    localparam int             IW       = $clog2(KEY_W + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(KEY_W - 1);

    state_t          r_state, w_next;
    logic [IW-1:0]   r_idx, w_idx_next;
    logic            w_load, w_shift;
    logic            w_lsb, w_lsb_next, w_parity;

    logic            r_key_bit, r_key_valid, r_busy, r_done;
    logic [IW-1:0]   r_bit_idx;
    logic            w_bit_n, w_valid_n, w_busy_n, w_done_n;
    logic [IW-1:0]   w_idx_n;

    key_shift_reg #(.W(KEY_W)) u_shift (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (key_word),
        .o_lsb      (w_lsb),
        .o_lsb_next (w_lsb_next),
        .o_parity   (w_parity)
    );

    // Handshake: a bit moves on a falling edge where key_valid && key_ready; while
    // key_valid && !key_ready, key_bit and bit_idx hold indefinitely. abort beats key_ready.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_idx_next = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next     = ST_LOAD;
                    w_load     = 1'b1;
                    w_idx_next = '0;
                end
            end
            ST_LOAD: w_next = abort ? ST_IDLE : ST_SEND;
            ST_SEND: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (key_ready) begin
                    w_shift    = 1'b1;
                    w_idx_next = r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_next = (PARITY_EN != 0) ? ST_PAR : ST_DONE;
                    end
                end
            end
            ST_PAR: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (key_ready) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (w_next == ST_IDLE) begin
            w_idx_next = '0;
        end

        // Outputs are decoded from the next state so they can be registered directly.
        w_valid_n = (w_next == ST_SEND) || (w_next == ST_PAR);
        w_busy_n  = w_valid_n || (w_next == ST_LOAD);
        w_done_n  = (w_next == ST_DONE);
        w_idx_n   = w_valid_n ? w_idx_next : '0;
        w_bit_n   = 1'b0;
        if (w_next == ST_SEND) begin
            w_bit_n = w_shift ? w_lsb_next : w_lsb;
        end else if (w_next == ST_PAR) begin
            w_bit_n = w_parity;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_key_bit   <= 1'b0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bit_idx   <= '0;
        end else begin
            r_state     <= w_next;
            r_idx       <= w_idx_next;
            r_key_bit   <= w_bit_n;
            r_key_valid <= w_valid_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_bit_idx   <= w_idx_n;
        end
    end

    assign key_bit   = r_key_bit;
    assign key_valid = r_key_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign bit_idx   = r_bit_idx;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_key_stream_tx.sv
// Bench for key_stream_tx: parity and no-parity instances share stimulus and are
// checked every cycle against a transaction-level model plus literal expectations.
module tb_key_stream_tx;

    logic        clk = 1'b1;
    logic        rst;
    logic [15:0] key_word;
    logic        start, abort, key_ready;
    logic [1:0]  o_bit, o_valid, o_busy, o_done;
    logic [4:0]  o_idx0, o_idx1;
    logic [2:0]  o_st0, o_st1;

    key_stream_tx #(.KEY_W(16), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .key_word(key_word), .start(start), .abort(abort),
        .key_ready(key_ready), .key_bit(o_bit[0]), .key_valid(o_valid[0]),
        .busy(o_busy[0]), .done(o_done[0]), .bit_idx(o_idx0), .dbg_state(o_st0)
    );

    key_stream_tx #(.KEY_W(16), .PARITY_EN(0)) dut_n (
        .clk(clk), .rst(rst), .key_word(key_word), .start(start), .abort(abort),
        .key_ready(key_ready), .key_bit(o_bit[1]), .key_valid(o_valid[1]),
        .busy(o_busy[1]), .done(o_done[1]), .bit_idx(o_idx1), .dbg_state(o_st1)
    );

    // ---------------- clock / counters ----------------
    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit run   = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Inputs change 2 time units after the rising edge, well clear of the active falling edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- transaction-level model ----------------
    bit [15:0] m_key  [2];
    int        m_sent [2];
    bit        m_act  [2];
    bit        m_ld   [2];
    bit        m_done [2];

    function automatic int nbits(input int k);
        return (k == 0) ? 17 : 16;
    endfunction

    initial forever begin
        @(negedge clk or negedge rst);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_act[k] = 0; m_ld[k] = 0; m_done[k] = 0; m_sent[k] = 0; m_key[k] = '0;
            end else if (m_done[k]) begin
                m_done[k] = 0;
            end else if (!m_act[k]) begin
                if (start) begin
                    m_act[k] = 1; m_ld[k] = 1; m_key[k] = key_word; m_sent[k] = 0;
                end
            end else if (abort) begin
                m_act[k] = 0;
            end else if (m_ld[k]) begin
                m_ld[k] = 0;
            end else if (key_ready) begin
                m_sent[k]++;
                if (m_sent[k] == nbits(k)) begin
                    m_act[k] = 0; m_done[k] = 1;
                end
            end
        end
    end

    function automatic bit m_valid(input int k);
        return m_act[k] && !m_ld[k];
    endfunction

    function automatic int m_bit(input int k);
        if (!m_valid(k)) return 0;
        if (m_sent[k] < 16) return int'(m_key[k][m_sent[k]]);
        return int'(^m_key[k]);
    endfunction

    // ---------------- compare process / scoreboard ----------------
    logic [0:0] exp_q0[$];
    logic [0:0] exp_q1[$];
    bit  mon_en0 = 0, mon_en1 = 0;
    int  done_cnt0 = 0, done_cnt1 = 0;
    int  last_done0 = 0, last_done1 = 0;
    int  done_q0[$];
    int  done_q1[$];

    initial forever begin
        @(posedge clk);
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("key_bit[%0d]", k),   int'(o_bit[k]),   m_bit(k));
                check($sformatf("key_valid[%0d]", k), int'(o_valid[k]), int'(m_valid(k)));
                check($sformatf("busy[%0d]", k),      int'(o_busy[k]),  int'(m_act[k]));
                check($sformatf("done[%0d]", k),      int'(o_done[k]),  int'(m_done[k]));
                check($sformatf("bit_idx[%0d]", k),   (k == 0) ? int'(o_idx0) : int'(o_idx1),
                      m_valid(k) ? m_sent[k] : 0);
            end
            if (o_done[0]) begin done_cnt0++; last_done0 = cyc; done_q0.push_back(cyc); end
            if (o_done[1]) begin done_cnt1++; last_done1 = cyc; done_q1.push_back(cyc); end
            if (mon_en0 && o_valid[0] && key_ready) begin
                if (exp_q0.size() == 0) fail("extra_bit_p");
                else check("bit_seq_p", int'(o_bit[0]), int'(exp_q0.pop_front()));
            end
            if (mon_en1 && o_valid[1] && key_ready) begin
                if (exp_q1.size() == 0) fail("extra_bit_n");
                else check("bit_seq_n", int'(o_bit[1]), int'(exp_q1.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int budget);
        int b0 = done_cnt0;
        int b1 = done_cnt1;
        int i  = 0;
        while ((done_cnt0 == b0 || done_cnt1 == b1) && i < budget) begin
            tick();
            i++;
        end
        if (done_cnt0 == b0 || done_cnt1 == b1) fail("done_timeout");
    endtask

    task automatic wait_idx(input int v, input int budget);
        int i = 0;
        while (int'(o_idx0) != v && i < budget) begin
            tick();
            i++;
        end
        if (int'(o_idx0) != v) fail($sformatf("wait_bit_idx_%0d", v));
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_key_bit[%0d]", tag, k),   int'(o_bit[k]),   0);
            check($sformatf("%s_key_valid[%0d]", tag, k), int'(o_valid[k]), 0);
            check($sformatf("%s_busy[%0d]", tag, k),      int'(o_busy[k]),  0);
            check($sformatf("%s_done[%0d]", tag, k),      int'(o_done[k]),  0);
        end
        check({tag, "_bit_idx_p"}, int'(o_idx0), 0);
        check({tag, "_bit_idx_n"}, int'(o_idx1), 0);
        check({tag, "_state_p"},   int'(o_st0),  0);
        check({tag, "_state_n"},   int'(o_st1),  0);
    endtask

    int seq_a5c3 [17] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,0};

    // ---------------- directed tests ----------------
    initial begin
        int s, b0, qb0, qb1, i;
        rst = 1'b0; start = 1'b0; abort = 1'b0; key_ready = 1'b0; key_word = '0;
        repeat (3) tick();
        check_all_zero("reset");
        run = 1'b1;
        rst = 1'b1;
        repeat (2) tick();

        // 1: A5C3, ready held high; key_word changed after capture must not matter
        key_word = 16'hA5C3; key_ready = 1'b1;
        for (int j = 0; j < 17; j++) exp_q0.push_back(1'(seq_a5c3[j]));
        mon_en0 = 1'b1;
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0; key_word = 16'hFFFF;
        wait_done(60);
        check("t1_latency_p", last_done0 - s, 19);
        check("t1_latency_n", last_done1 - s, 18);
        check("t1_bits_left_p", exp_q0.size(), 0);
        mon_en0 = 1'b0;
        repeat (3) tick();

        // 2: same key, key_ready toggling 1,0,1,0... from the cycle after start
        key_word = 16'hA5C3; key_ready = 1'b0;
        for (int j = 0; j < 17; j++) exp_q0.push_back(1'(seq_a5c3[j]));
        mon_en0 = 1'b1;
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        b0 = done_cnt0;
        i = 0;
        while (done_cnt0 == b0 && i < 100) begin
            key_ready = ~key_ready;
            tick();
            i++;
        end
        if (done_cnt0 == b0) fail("t2_done_timeout");
        check("t2_latency_p", last_done0 - s, 36);
        check("t2_latency_n", last_done1 - s, 34);
        check("t2_bits_left_p", exp_q0.size(), 0);
        mon_en0 = 1'b0; key_ready = 1'b1;
        repeat (3) tick();

        // 3: abort while bit_idx = 7, then restart one cycle later
        key_word = 16'h3C5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(7, 40);
        b0 = done_cnt0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_valid_after_abort", int'(o_valid[0]), 0);
        check("t3_busy_after_abort",  int'(o_busy[0]),  0);
        check("t3_state_after_abort", int'(o_st0),      0);
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        check("t3_restart_busy", int'(o_busy[0]), 1);
        check("t3_no_done_on_abort", done_cnt0 - b0, 0);
        wait_done(60);
        check("t3_done_count", done_cnt0 - b0, 1);
        check("t3_latency_p", last_done0 - s, 19);
        repeat (3) tick();

        // 4: asynchronous reset while bit_idx = 10
        key_word = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(10, 40);
        b0 = done_cnt0;
        #1 rst = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (3) tick();
        rst = 1'b1;
        key_word = 16'hBEEF;
        repeat (6) tick();
        check_all_zero("after_release");
        check("t4_no_done", done_cnt0 - b0, 0);

        // 5: key 0001, no-parity instance sends 1 then fifteen 0s
        key_word = 16'h0001;
        exp_q1.push_back(1'b1);
        for (int j = 0; j < 15; j++) exp_q1.push_back(1'b0);
        mon_en1 = 1'b1;
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        wait_done(60);
        check("t5_latency_n", last_done1 - s, 18);
        check("t5_latency_p", last_done0 - s, 19);
        check("t5_bits_left_n", exp_q1.size(), 0);
        mon_en1 = 1'b0;
        repeat (3) tick();

        // 6: start held high, back-to-back transfers
        key_word = 16'h8001;
        qb0 = done_q0.size(); qb1 = done_q1.size();
        start = 1'b1; s = cyc;
        i = 0;
        while (done_q0.size() < qb0 + 3 && i < 200) begin
            tick();
            i++;
        end
        start = 1'b0;
        if (done_q0.size() < qb0 + 3 || done_q1.size() < qb1 + 3) begin
            fail("t6_done_timeout");
        end else begin
            check("t6_first_latency_p", done_q0[qb0] - s, 19);
            check("t6_gap1_p", done_q0[qb0+1] - done_q0[qb0],   20);
            check("t6_gap2_p", done_q0[qb0+2] - done_q0[qb0+1], 20);
            check("t6_first_latency_n", done_q1[qb1] - s, 18);
            check("t6_gap1_n", done_q1[qb1+1] - done_q1[qb1],   19);
            check("t6_gap2_n", done_q1[qb1+2] - done_q1[qb1+1], 19);
        end
        repeat (25) tick();
        check_all_zero("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
